// File: rtl/hid_key_decoder.sv
// Keyboard-report to key-press event decoder with an ASCII translator and a FWFT event FIFO.
// Optional typematic auto-repeat is enabled by defining HID_KEY_DECODER_TYPEMATIC_EN.
//
//   state  | meaning
//   IDLE   | waiting for a report strobe
//   SCAN   | evaluating snapshot slot slot_q, pushing a press event if it is new
//   COMMIT | previous-key set takes the snapshot (skipped for rollover reports)
module hid_key_decoder #(
   parameter int FIFO_DEPTH   = 8,
   parameter int REPEAT_DELAY = 6000000,
   parameter int REPEAT_RATE  = 1200000
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic [1:0]                    usb_type,
   input  logic                          usb_report,
   input  logic [7:0]                    key_modifiers,
   input  logic [7:0]                    key1,
   input  logic [7:0]                    key2,
   input  logic [7:0]                    key3,
   input  logic [7:0]                    key4,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [7:0]                    out_code,
   output logic [7:0]                    out_ascii,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

   state_t          state_q, state_d;
   logic [3:0][7:0] snap_q, snap_d, prev_q, prev_d, keys_in;
   logic [1:0]      slot_q, slot_d;
   logic            shift_q, shift_d, ctrl_q, ctrl_d, discard_q, discard_d;
   logic            rollover_in, kbd_rpt, scan_push, rpt_push, push_req;
   logic [7:0]      code, rpt_code, push_code;
   logic            unused_mod;

   assign keys_in    = {key4, key3, key2, key1};
   assign kbd_rpt    = usb_report && (usb_type == 2'd1);
   assign unused_mod = ^{key_modifiers[7:6], key_modifiers[3:2]};

   function automatic logic [7:0] to_ascii(input logic [7:0] c, input logic sh, input logic ct);
      logic [7:0] a;
      a = 8'h00;
      if (c >= 8'h04 && c <= 8'h1D) begin
         a = (sh ? 8'h41 : 8'h61) + (c - 8'h04);
         if (ct) a = a & 8'h1F;
      end else begin
         case (c)
            8'h1E: a = sh ? 8'h21 : 8'h31;
            8'h1F: a = sh ? 8'h40 : 8'h32;
            8'h20: a = sh ? 8'h23 : 8'h33;
            8'h21: a = sh ? 8'h24 : 8'h34;
            8'h22: a = sh ? 8'h25 : 8'h35;
            8'h23: a = sh ? 8'h5E : 8'h36;
            8'h24: a = sh ? 8'h26 : 8'h37;
            8'h25: a = sh ? 8'h2A : 8'h38;
            8'h26: a = sh ? 8'h28 : 8'h39;
            8'h27: a = sh ? 8'h29 : 8'h30;
            8'h28: a = 8'h0D;
            8'h29: a = 8'h1B;
            8'h2A: a = 8'h08;
            8'h2B: a = 8'h09;
            8'h2C: a = 8'h20;
            8'h2D: a = sh ? 8'h5F : 8'h2D;
            8'h2E: a = sh ? 8'h2B : 8'h3D;
            8'h2F: a = sh ? 8'h7B : 8'h5B;
            8'h30: a = sh ? 8'h7D : 8'h5D;
            8'h31: a = sh ? 8'h7C : 8'h5C;
            8'h33: a = sh ? 8'h3A : 8'h3B;
            8'h34: a = sh ? 8'h22 : 8'h27;
            8'h35: a = sh ? 8'h7E : 8'h60;
            8'h36: a = sh ? 8'h3C : 8'h2C;
            8'h37: a = sh ? 8'h3E : 8'h2E;
            8'h38: a = sh ? 8'h3F : 8'h2F;
            default: a = 8'h00;
         endcase
      end
      return a;
   endfunction

   always_comb begin
      rollover_in = 1'b0;
      for (int i = 0; i < 4; i++)
         if (keys_in[i] >= 8'h01 && keys_in[i] <= 8'h03) rollover_in = 1'b1;
   end

   // A slot is a press if it is a real key, absent last time, and not a repeat within this snapshot.
   always_comb begin
      code      = snap_q[slot_q];
      scan_push = (state_q == SCAN) && (code >= 8'h04);
      for (int j = 0; j < 4; j++) begin
         if (prev_q[j] == code) scan_push = 1'b0;
         if (j < int'(slot_q) && snap_q[j] == code) scan_push = 1'b0;
      end
   end

   always_comb begin
      state_d   = state_q;
      snap_d    = snap_q;
      prev_d    = prev_q;
      slot_d    = slot_q;
      shift_d   = shift_q;
      ctrl_d    = ctrl_q;
      discard_d = discard_q;
      case (state_q)
         IDLE: begin
            if (kbd_rpt) begin
               snap_d    = keys_in;
               shift_d   = key_modifiers[1] | key_modifiers[5];
               ctrl_d    = key_modifiers[0] | key_modifiers[4];
               slot_d    = 2'd0;
               discard_d = rollover_in;
               state_d   = rollover_in ? COMMIT : SCAN;
            end else if (usb_report) begin
               prev_d = '0;
            end
         end
         SCAN: begin
            slot_d = slot_q + 2'd1;
            if (slot_q == 2'd3) state_d = COMMIT;
         end
         COMMIT: begin
            if (!discard_q) prev_d = snap_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         snap_q    <= '0;
         prev_q    <= '0;
         slot_q    <= 2'd0;
         shift_q   <= 1'b0;
         ctrl_q    <= 1'b0;
         discard_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         snap_q    <= snap_d;
         prev_q    <= prev_d;
         slot_q    <= slot_d;
         shift_q   <= shift_d;
         ctrl_q    <= ctrl_d;
         discard_q <= discard_d;
      end
   end

`ifdef HID_KEY_DECODER_TYPEMATIC_EN
   logic        rpt_arm_q, rpt_arm_d, rpt_pend_q, rpt_pend_d, key_seen, rpt_due, rpt_kill;
   logic [7:0]  rpt_key_q, rpt_key_d, rpt_pcode_q, rpt_pcode_d;
   logic [31:0] rpt_cnt_q, rpt_cnt_d;

   always_comb begin
      key_seen = 1'b0;
      for (int i = 0; i < 4; i++)
         if (keys_in[i] == rpt_key_q) key_seen = 1'b1;
   end

   assign rpt_kill = (state_q == IDLE) && usb_report && (!kbd_rpt || rollover_in || !key_seen);
   assign rpt_due  = rpt_pend_q || (rpt_arm_q && rpt_cnt_q == 32'd1);
   assign rpt_push = rpt_due && !scan_push && !rpt_kill;
   assign rpt_code = rpt_pend_q ? rpt_pcode_q : rpt_key_q;

   // A repeat that loses arbitration to a scan press is held pending with its own code.
   always_comb begin
      rpt_arm_d   = rpt_arm_q;
      rpt_key_d   = rpt_key_q;
      rpt_cnt_d   = rpt_cnt_q;
      rpt_pend_d  = rpt_due && scan_push && !rpt_kill;
      rpt_pcode_d = rpt_pend_q ? rpt_pcode_q : rpt_key_q;
      if (rpt_kill) begin
         rpt_arm_d = 1'b0;
      end else if (scan_push) begin
         rpt_arm_d = 1'b1;
         rpt_key_d = code;
         rpt_cnt_d = 32'(REPEAT_DELAY);
      end else if (rpt_arm_q) begin
         rpt_cnt_d = (rpt_cnt_q == 32'd1) ? 32'(REPEAT_RATE) : rpt_cnt_q - 32'd1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rpt_arm_q   <= 1'b0;
         rpt_key_q   <= 8'h00;
         rpt_cnt_q   <= '0;
         rpt_pend_q  <= 1'b0;
         rpt_pcode_q <= 8'h00;
      end else begin
         rpt_arm_q   <= rpt_arm_d;
         rpt_key_q   <= rpt_key_d;
         rpt_cnt_q   <= rpt_cnt_d;
         rpt_pend_q  <= rpt_pend_d;
         rpt_pcode_q <= rpt_pcode_d;
      end
   end
`else
   localparam int unused_rpt_cfg = REPEAT_DELAY + REPEAT_RATE;
   assign rpt_push = 1'b0;
   assign rpt_code = 8'h00;
`endif

   assign push_req  = scan_push || rpt_push;
   assign push_code = scan_push ? code : rpt_code;

   logic [7:0]  code_mem  [FIFO_DEPTH];
   logic [7:0]  ascii_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          ovf_q, pop, full, accept;

   assign pop    = (count_q != '0) && out_ready;
   assign full   = (count_q == (AW+1)'(FIFO_DEPTH));
   assign accept = push_req && (!full || pop);

   always_ff @(posedge clk) begin
      if (accept) begin
         code_mem[wr_ptr_q]  <= push_code;
         ascii_mem[wr_ptr_q] <= to_ascii(push_code, shift_q, ctrl_q);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (accept && !pop) count_q <= count_q + 1'b1;
         else if (!accept && pop) count_q <= count_q - 1'b1;
         if (push_req && !accept) ovf_q <= 1'b1;
      end
   end

   assign out_valid  = (count_q != '0);
   assign out_code   = out_valid ? code_mem[rd_ptr_q] : 8'h00;
   assign out_ascii  = out_valid ? ascii_mem[rd_ptr_q] : 8'h00;
   assign overflow   = ovf_q;
   assign fifo_count = count_q;
endmodule

// File: tb/tb_hid_key_decoder.sv
// Directed bench for hid_key_decoder: expected events are queued as reports are sent and
// compared against the events observed leaving the FIFO.
module tb_hid_key_decoder;
   logic       clk = 1'b0;
   logic       resetn;
   logic [1:0] usb_type = 2'd0;
   logic       usb_report = 1'b0;
   logic [7:0] key_modifiers = 8'h00;
   logic [7:0] key1 = 8'h00, key2 = 8'h00, key3 = 8'h00, key4 = 8'h00;
   logic       out_valid, out_ready = 1'b0, overflow;
   logic [7:0] out_code, out_ascii;
   logic [3:0] fifo_count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [7:0] code;
      logic [7:0] ascii;
      int         cyc;
   } ev_t;

   logic [15:0] exp_q[$];
   ev_t         obs_q[$];

   always #5 clk = ~clk;

   hid_key_decoder #(.FIFO_DEPTH(8), .REPEAT_DELAY(20), .REPEAT_RATE(5)) dut (
      .clk(clk), .resetn(resetn), .usb_type(usb_type), .usb_report(usb_report),
      .key_modifiers(key_modifiers), .key1(key1), .key2(key2), .key3(key3), .key4(key4),
      .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
      .out_ascii(out_ascii), .overflow(overflow), .fifo_count(fifo_count)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk)
      if (resetn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1)
         obs_q.push_back('{out_code, out_ascii, cyc});

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [7:0] k1, k2, k3, k4, input logic [7:0] mods,
                         input logic [1:0] typ);
      usb_type = typ; key1 = k1; key2 = k2; key3 = k3; key4 = k4;
      key_modifiers = mods;
      usb_report = 1'b1;
      tick(1);
      usb_report = 1'b0;
   endtask

   task automatic send(input logic [7:0] k1, k2, k3, k4, input logic [7:0] mods);
      strobe(k1, k2, k3, k4, mods, 2'd1);
      tick(7);
   endtask

   task automatic expect_ev(input logic [7:0] c, input logic [7:0] a);
      exp_q.push_back({c, a});
   endtask

   task automatic drain_check(input string tag);
      logic [15:0] e;
      ev_t o;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk({tag, "_present"}, 32'(obs_q.size() != 0), 32'd1);
         if (obs_q.size() != 0) begin
            o = obs_q.pop_front();
            chk({tag, "_code"}, 32'(o.code), 32'(e[15:8]));
            chk({tag, "_ascii"}, 32'(o.ascii), 32'(e[7:0]));
         end
      end
      chk({tag, "_extra"}, 32'(obs_q.size()), 32'd0);
      obs_q.delete();
   endtask

   function automatic logic [7:0] ref_ascii(input logic [7:0] c, input logic [7:0] m);
      string lc, dg, dgs, pu, pus;
      logic sh, ct;
      logic [7:0] r;
      lc = "abcdefghijklmnopqrstuvwxyz";
      dg = "1234567890";
      dgs = "!@#$%^&*()";
      pu = "-=[]\\ ;'`,./";
      pus = "_+{}| :\"~<>?";
      sh = m[1] | m[5];
      ct = m[0] | m[4];
      r = 8'h00;
      if (c >= 8'h04 && c <= 8'h1D) begin
         r = lc[int'(c) - 4];
         if (sh) r = r - 8'h20;
         if (ct) r = r & 8'h1F;
      end else if (c >= 8'h1E && c <= 8'h27) r = sh ? dgs[int'(c) - 'h1E] : dg[int'(c) - 'h1E];
      else if (c == 8'h28) r = 8'h0D;
      else if (c == 8'h29) r = 8'h1B;
      else if (c == 8'h2A) r = 8'h08;
      else if (c == 8'h2B) r = 8'h09;
      else if (c == 8'h2C) r = 8'h20;
      else if (c >= 8'h2D && c <= 8'h38 && c != 8'h32)
         r = sh ? pus[int'(c) - 'h2D] : pu[int'(c) - 'h2D];
      return r;
   endfunction

   initial begin
      resetn = 1'b0;
      tick(3);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_code", 32'(out_code), 32'd0);
      chk("rst_ascii", 32'(out_ascii), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      resetn = 1'b1;
      out_ready = 1'b1;
      tick(2);

      // first press and its latency
      expect_ev(8'h04, 8'h61);
      strobe(8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 2'd1);
      chk("lat_n1_valid", 32'(out_valid), 32'd0);
      tick(1);
      chk("lat_n2_valid", 32'(out_valid), 32'd1);
      chk("lat_n2_code", 32'(out_code), 32'h04);
      chk("lat_n2_ascii", 32'(out_ascii), 32'h61);
      tick(6);
      drain_check("press_a");

      send(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      expect_ev(8'h04, 8'h41);
      send(8'h04, 8'h00, 8'h00, 8'h00, 8'h02);
      send(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      expect_ev(8'h06, 8'h03);
      send(8'h06, 8'h00, 8'h00, 8'h00, 8'h01);
      drain_check("modifiers");

      // diff against the previous report
      send(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      expect_ev(8'h04, 8'h61);
      expect_ev(8'h05, 8'h62);
      send(8'h04, 8'h05, 8'h00, 8'h00, 8'h00);
      expect_ev(8'h06, 8'h63);
      send(8'h05, 8'h06, 8'h00, 8'h00, 8'h00);
      send(8'h05, 8'h06, 8'h00, 8'h00, 8'h00);
      drain_check("diff");

      // rollover keeps the previous set
      send(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      expect_ev(8'h04, 8'h61);
      send(8'h04, 8'h00, 8'h00, 8'h00, 8'h00);
      send(8'h01, 8'h01, 8'h01, 8'h01, 8'h00);
      send(8'h04, 8'h00, 8'h00, 8'h00, 8'h00);
      drain_check("rollover");

      // duplicate slot and non-keyboard report
      send(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      expect_ev(8'h07, 8'h64);
      send(8'h07, 8'h07, 8'h00, 8'h00, 8'h00);
      expect_ev(8'h08, 8'h65);
      send(8'h08, 8'h00, 8'h00, 8'h00, 8'h00);
      strobe(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'd2);
      tick(3);
      expect_ev(8'h08, 8'h65);
      send(8'h08, 8'h00, 8'h00, 8'h00, 8'h00);
      drain_check("dup_type");

      // translation table samples
      send(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      expect_ev(8'h1E, ref_ascii(8'h1E, 8'h00));
      expect_ev(8'h2C, ref_ascii(8'h2C, 8'h00));
      expect_ev(8'h28, ref_ascii(8'h28, 8'h00));
      expect_ev(8'h31, ref_ascii(8'h31, 8'h00));
      send(8'h1E, 8'h2C, 8'h28, 8'h31, 8'h00);
      send(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      expect_ev(8'h1F, ref_ascii(8'h1F, 8'h20));
      expect_ev(8'h2D, ref_ascii(8'h2D, 8'h20));
      expect_ev(8'h32, 8'h00);
      expect_ev(8'h38, ref_ascii(8'h38, 8'h20));
      send(8'h1F, 8'h2D, 8'h32, 8'h38, 8'h20);
      send(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      expect_ev(8'h3A, 8'h00);
      expect_ev(8'h27, ref_ascii(8'h27, 8'h02));
      expect_ev(8'h10, ref_ascii(8'h10, 8'h02));
      expect_ev(8'h34, ref_ascii(8'h34, 8'h02));
      send(8'h3A, 8'h27, 8'h10, 8'h34, 8'h02);
      send(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      expect_ev(8'h10, 8'h0D);
      send(8'h10, 8'h00, 8'h00, 8'h00, 8'h10);
      drain_check("xlate");

      // overflow, push+pop while full, drain order
      send(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      out_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (i < 8) expect_ev(8'(8'h04 + i), 8'(8'h61 + i));
         send(8'(8'h04 + i), 8'h00, 8'h00, 8'h00, 8'h00);
      end
      chk("full_count", 32'(fifo_count), 32'd8);
      chk("full_ovf", 32'(overflow), 32'd1);
      chk("full_head", 32'(out_code), 32'h04);
      expect_ev(8'h0D, 8'h6A);
      strobe(8'h0D, 8'h00, 8'h00, 8'h00, 8'h00, 2'd1);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      chk("pushpop_count", 32'(fifo_count), 32'd8);
      tick(4);
      out_ready = 1'b1;
      tick(12);
      chk("drained_count", 32'(fifo_count), 32'd0);
      chk("ovf_sticky", 32'(overflow), 32'd1);
      drain_check("overflow");

      // asynchronous reset discards queued events
      out_ready = 1'b0;
      send(8'h05, 8'h00, 8'h00, 8'h00, 8'h00);
      #3 resetn = 1'b0;
      #1;
      chk("midrst_count", 32'(fifo_count), 32'd0);
      chk("midrst_ovf", 32'(overflow), 32'd0);
      tick(2);
      resetn = 1'b1;
      out_ready = 1'b1;
      tick(2);

`ifdef HID_KEY_DECODER_TYPEMATIC_EN
      for (int i = 0; i < 4; i++) expect_ev(8'h04, 8'h61);
      strobe(8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 2'd1);
      tick(9);
      strobe(8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 2'd1);
      tick(9);
      strobe(8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 2'd1);
      tick(9);
      strobe(8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 2'd1);
      tick(2);
      strobe(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'd1);
      tick(40);
      chk("rpt_events", 32'(obs_q.size()), 32'd4);
      if (obs_q.size() >= 4) begin
         chk("rpt_first", 32'(obs_q[1].cyc - obs_q[0].cyc), 32'd20);
         chk("rpt_second", 32'(obs_q[2].cyc - obs_q[1].cyc), 32'd5);
         chk("rpt_third", 32'(obs_q[3].cyc - obs_q[2].cyc), 32'd5);
      end
      drain_check("typematic");
`else
      expect_ev(8'h04, 8'h61);
      for (int i = 0; i < 5; i++) send(8'h04, 8'h00, 8'h00, 8'h00, 8'h00);
      tick(20);
      drain_check("held_once");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
